// File: rtl/sram_port_arbiter.sv
// Two-master arbiter in front of a single SRAM controller port: grants one
// registered transaction at a time, returns a one-cycle ready pulse, and has a watchdog.
module sram_port_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_rd_en,
  input  logic        m0_wr_en,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [63:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_rd_en,
  input  logic        m1_wr_en,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [63:0] m1_rdata,
  output logic        m1_ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_err,
  output logic [1:0]  state_dbg
);

  // Handshake: mX_rd_en/mX_wr_en are held until the one-cycle mX_ready pulse;
  // a request still asserted when the arbiter is back in IDLE is a new request.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam bit              RR_EN   = (ROUND_ROBIN != 0);
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t          state, state_nxt;
  logic            m0_req, m1_req;
  logic            grant_sel;
  logic            owner, last_owner;
  logic            op_wr;
  logic [31:0]     addr_q, wdata_q;
  logic [TO_W-1:0] cnt;
  logic [63:0]     m0_rdata_q, m1_rdata_q;
  logic            timeout_q;
  logic            expire;

  assign m0_req = m0_rd_en | m0_wr_en;
  assign m1_req = m1_rd_en | m1_wr_en;

  // On contention, round-robin picks whoever did not own the last completed transaction.
  always_comb begin
    grant_sel = m1_req;
    if (m0_req && m1_req) begin
      grant_sel = RR_EN ? ~last_owner : 1'b0;
    end
  end

  // sram_ready takes precedence over a same-cycle watchdog expiry.
  assign expire = (state == S_BUSY) && !sram_ready && TO_EN && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (m0_req || m1_req) state_nxt = S_BUSY;
      S_BUSY:  if (sram_ready || expire) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      S_BUSY: begin
        sram_rd_en = ~op_wr;
        sram_wr_en = op_wr;
        busy       = 1'b1;
      end
      S_RESP: begin
        m0_ready = ~owner;
        m1_ready = owner;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b1;
      last_owner <= 1'b1;
      op_wr      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            owner   <= grant_sel;
            op_wr   <= grant_sel ? m1_wr_en : m0_wr_en;
            addr_q  <= grant_sel ? m1_addr  : m0_addr;
            wdata_q <= grant_sel ? m1_wdata : m0_wdata;
            cnt     <= '0;
          end
        end
        S_BUSY: begin
          if (sram_ready) begin
            if (owner) m1_rdata_q <= op_wr ? 64'd0 : sram_rdata;
            else       m0_rdata_q <= op_wr ? 64'd0 : sram_rdata;
          end else begin
            cnt <= cnt + TO_W'(1);
            if (expire) begin
              timeout_q <= 1'b1;
              if (owner) m1_rdata_q <= 64'd0;
              else       m0_rdata_q <= 64'd0;
            end
          end
        end
        S_RESP: last_owner <= owner;
        default: ;
      endcase
    end
  end

  assign sram_addr   = addr_q;
  assign sram_wdata  = wdata_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign grant_id    = owner;
  assign timeout_err = timeout_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a round-robin instance and a fixed-priority
// instance share all inputs; outputs are sampled 1 ns after each rising edge.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_rd_en = 0, m0_wr_en = 0, m1_rd_en = 0, m1_wr_en = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [63:0] sram_rdata = 0;
  logic        sram_ready = 0;

  logic [63:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready, sram_rd_en, sram_wr_en, busy, grant_id, timeout_err;
  logic [31:0] sram_addr, sram_wdata;
  logic [1:0]  state_dbg;

  logic [63:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_m0_ready, fp_m1_ready, fp_sram_rd_en, fp_sram_wr_en, fp_busy, fp_grant_id, fp_timeout_err;
  logic [31:0] fp_sram_addr, fp_sram_wdata;
  logic [1:0]  fp_state_dbg;

  int total = 0;
  int bad   = 0;

  sram_port_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  sram_port_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(8), .TO_W(4)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(fp_m0_rdata), .m0_ready(fp_m0_ready),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(fp_m1_rdata), .m1_ready(fp_m1_ready),
    .sram_rd_en(fp_sram_rd_en), .sram_wr_en(fp_sram_wr_en), .sram_addr(fp_sram_addr),
    .sram_wdata(fp_sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .busy(fp_busy), .grant_id(fp_grant_id), .timeout_err(fp_timeout_err), .state_dbg(fp_state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_rd_en = 0; m0_wr_en = 0; m1_rd_en = 0; m1_wr_en = 0;
    m0_addr = 0; m0_wdata = 0; m1_addr = 0; m1_wdata = 0;
    sram_ready = 0; sram_rdata = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if ({sram_rd_en, sram_wr_en, m0_ready, m1_ready} !== 4'b0) begin bad++; $display("FAIL reset_strobes: got %b want 0000", {sram_rd_en, sram_wr_en, m0_ready, m1_ready}); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    total++; if ({sram_addr, sram_wdata} !== 64'd0) begin bad++; $display("FAIL reset_sram_bus: got %h want 0", {sram_addr, sram_wdata}); end
    total++; if ({m0_rdata, m1_rdata} !== 128'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_single_read();
    int rd_cycles = 0;
    int bad_strobes = 0;
    m0_rd_en = 1; m0_addr = 32'h0000_0400;
    step();
    total++; if ({busy, grant_id, sram_addr} !== {1'b1, 1'b0, 32'h400}) begin bad++; $display("FAIL t1_grant: got busy=%b gid=%b addr=%h want 1 0 400", busy, grant_id, sram_addr); end
    for (int i = 0; i < 4; i++) begin
      if (sram_rd_en) rd_cycles++;
      if (sram_wr_en || m0_ready || m1_ready) bad_strobes++;
      if (i == 3) begin sram_ready = 1; sram_rdata = 64'hAAAA_BBBB_CCCC_DDDD; end
      step();
    end
    sram_ready = 0; sram_rdata = 64'h0; m0_rd_en = 0;
    total++; if (rd_cycles != 4) begin bad++; $display("FAIL t1_rd_cycles: got %0d want 4", rd_cycles); end
    total++; if (bad_strobes != 0) begin bad++; $display("FAIL t1_busy_strobes: got %0d want 0", bad_strobes); end
    total++; if ({m0_ready, m1_ready, sram_rd_en} !== 3'b100) begin bad++; $display("FAIL t1_resp: got %b want 100", {m0_ready, m1_ready, sram_rd_en}); end
    total++; if (m0_rdata !== 64'hAAAA_BBBB_CCCC_DDDD) begin bad++; $display("FAIL t1_rdata: got %h want aaaabbbbccccdddd", m0_rdata); end
    step();
    total++; if ({m0_ready, m1_ready, busy} !== 3'b000) begin bad++; $display("FAIL t1_after: got %b want 000", {m0_ready, m1_ready, busy}); end
    total++; if (m0_rdata !== 64'hAAAA_BBBB_CCCC_DDDD) begin bad++; $display("FAIL t1_rdata_hold: got %h want aaaabbbbccccdddd", m0_rdata); end
  endtask

  task automatic test_contention();
    logic rr_got [4];
    logic fp_got [4];
    logic rr_exp [4];
    int n = 0;
    int both = 0;
    rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 0; rr_exp[3] = 1;
    apply_reset();
    m0_rd_en = 1; m0_addr = 32'h100;
    m1_rd_en = 1; m1_addr = 32'h200;
    for (int c = 0; c < 40 && n < 4; c++) begin
      sram_ready = sram_rd_en;
      sram_rdata = 64'h1000 + 64'(c);
      step();
      if (m0_ready && m1_ready) both++;
      if (m0_ready || m1_ready) begin
        rr_got[n] = m1_ready;
        fp_got[n] = fp_m1_ready;
        total++; if (grant_id !== rr_exp[n]) begin bad++; $display("FAIL t2_grant_id[%0d]: got %b want %b", n, grant_id, rr_exp[n]); end
        n++;
      end
    end
    m0_rd_en = 0; m1_rd_en = 0; sram_ready = 0;
    total++; if (n != 4) begin bad++; $display("FAIL t2_completions: got %0d want 4", n); end
    total++; if (both != 0) begin bad++; $display("FAIL t2_dual_ready: got %0d want 0", both); end
    for (int i = 0; i < n; i++) begin
      total++; if (rr_got[i] !== rr_exp[i]) begin bad++; $display("FAIL t2_rr_order[%0d]: got M%0d want M%0d", i, rr_got[i], rr_exp[i]); end
      total++; if (fp_got[i] !== 1'b0) begin bad++; $display("FAIL t2_fp_order[%0d]: got M%0d want M0", i, fp_got[i]); end
    end
    step();
    step();
  endtask

  task automatic test_write_hold();
    int bad_cycles = 0;
    m1_rd_en = 1; m1_wr_en = 1; m1_addr = 32'h404; m1_wdata = 32'h1234_5678;
    step();
    m1_addr = 32'h808; m1_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      if ({sram_wr_en, sram_rd_en, grant_id} !== 3'b101 || sram_addr !== 32'h404 || sram_wdata !== 32'h1234_5678) bad_cycles++;
      if (i == 2) begin sram_ready = 1; sram_rdata = 64'hFFFF_FFFF_FFFF_FFFF; end
      step();
    end
    sram_ready = 0; m1_rd_en = 0; m1_wr_en = 0;
    total++; if (bad_cycles != 0) begin bad++; $display("FAIL t3_busy_bus: got %0d bad cycles want 0", bad_cycles); end
    total++; if ({m1_ready, m0_ready} !== 2'b10) begin bad++; $display("FAIL t3_ready: got %b want 10", {m1_ready, m0_ready}); end
    total++; if (m1_rdata !== 64'd0) begin bad++; $display("FAIL t3_wr_rdata: got %h want 0", m1_rdata); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_idle: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int busy_cycles = 0;
    m0_rd_en = 1; m0_addr = 32'h500; sram_rdata = 64'h1111_2222_3333_4444;
    step();
    for (int i = 0; i < 20 && !m0_ready; i++) begin
      if (sram_rd_en) busy_cycles++;
      step();
    end
    m0_rd_en = 0;
    total++; if (busy_cycles != 8) begin bad++; $display("FAIL t4_busy_cycles: got %0d want 8", busy_cycles); end
    total++; if ({m0_ready, timeout_err} !== 2'b11) begin bad++; $display("FAIL t4_release: got %b want 11", {m0_ready, timeout_err}); end
    total++; if (m0_rdata !== 64'd0) begin bad++; $display("FAIL t4_rdata: got %h want 0", m0_rdata); end
    step();
    total++; if ({busy, timeout_err} !== 2'b01) begin bad++; $display("FAIL t4_sticky: got %b want 01", {busy, timeout_err}); end
    m1_rd_en = 1; m1_addr = 32'h600;
    step();
    step();
    sram_ready = 1; sram_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    sram_ready = 0; m1_rd_en = 0;
    total++; if ({m1_ready, timeout_err} !== 2'b11) begin bad++; $display("FAIL t4_next_txn: got %b want 11", {m1_ready, timeout_err}); end
    total++; if (m1_rdata !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL t4_next_rdata: got %h want 0123456789abcdef", m1_rdata); end
    step();
  endtask

  task automatic test_reset_mid_busy();
    m0_rd_en = 1; m0_addr = 32'h700;
    step();
    sram_ready = 1; sram_rdata = 64'h55;
    step();
    sram_ready = 0; m0_rd_en = 0;
    step();
    m0_rd_en = 1; m0_addr = 32'h704;
    step();
    step();
    total++; if (sram_rd_en !== 1'b1) begin bad++; $display("FAIL t5_in_busy: got %b want 1", sram_rd_en); end
    rst = 1; m0_rd_en = 0;
    step();
    total++; if ({sram_rd_en, busy, m0_ready, timeout_err} !== 4'b0000) begin bad++; $display("FAIL t5_abort: got %b want 0000", {sram_rd_en, busy, m0_ready, timeout_err}); end
    rst = 0;
    step();
    total++; if ({m0_ready, m1_ready, busy} !== 3'b000) begin bad++; $display("FAIL t5_no_pulse: got %b want 000", {m0_ready, m1_ready, busy}); end
    m0_rd_en = 1; m0_addr = 32'h710; m1_rd_en = 1; m1_addr = 32'h720;
    step();
    total++; if ({grant_id, sram_addr} !== {1'b0, 32'h710}) begin bad++; $display("FAIL t5_tie: got gid=%b addr=%h want 0 710", grant_id, sram_addr); end
    sram_ready = 1; sram_rdata = 64'h77;
    step();
    sram_ready = 0; m0_rd_en = 0; m1_rd_en = 0;
    total++; if ({m0_ready, m1_ready} !== 2'b10) begin bad++; $display("FAIL t5_ready: got %b want 10", {m0_ready, m1_ready}); end
    step();
  endtask

  task automatic test_last_cycle_ready();
    int busy_cycles = 0;
    m1_rd_en = 1; m1_addr = 32'h900;
    step();
    for (int i = 0; i < 8; i++) begin
      if (sram_rd_en) busy_cycles++;
      if (i == 7) begin sram_ready = 1; sram_rdata = 64'hCAFE_F00D_1234_0006; end
      step();
    end
    sram_ready = 0; m1_rd_en = 0;
    total++; if (busy_cycles != 8) begin bad++; $display("FAIL t6_busy_cycles: got %0d want 8", busy_cycles); end
    total++; if ({m1_ready, timeout_err} !== 2'b10) begin bad++; $display("FAIL t6_complete: got %b want 10", {m1_ready, timeout_err}); end
    total++; if (m1_rdata !== 64'hCAFE_F00D_1234_0006) begin bad++; $display("FAIL t6_rdata: got %h want cafef00d12340006", m1_rdata); end
    step();
    sram_ready = 1;
    step();
    sram_ready = 0;
    total++; if ({busy, m0_ready, m1_ready, timeout_err} !== 4'b0000) begin bad++; $display("FAIL t6_idle_ready_ignored: got %b want 0000", {busy, m0_ready, m1_ready, timeout_err}); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_hold();
    test_timeout();
    test_reset_mid_busy();
    test_last_cycle_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
